// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types, FSM encoding and the branch condition codes
// used by decode and the branch comparator.
package fetch_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} fetch_state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
   typedef enum logic [2:0] {NOB, BEQ, BNE, BLT, BGE, BLTU, BGEU, JMP} branch_cond_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request/response channel plus the decode hand-off.
interface fetch_pc_unit_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        flush;
   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, flush,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, flush,
      output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO (power-of-2 depth) with clear and occupancy count.
module fetch_fifo #(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clr,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  T                        i_data,
   output T                        o_data,
   output logic [$clog2(DEPTH):0]  o_count
);
   localparam int AW = $clog2(DEPTH);
   T              r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   assign o_data  = r_mem[r_rp];
   assign o_count = r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_mem <= '{default: '0};
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + AW'(1);
         end
         if (i_pop)
            r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner, in-order imem fetch with credit flow control, redirect/flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned branch targets halt fetch and raise a trap.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            branched,
   input  logic [31:0]     branch_target,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic            misalign_trap,
   output logic [31:0]     misalign_addr,
`endif
   fetch_pc_unit_if.master bus
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [1:0]  S_BOOT  = BOOT;
   localparam logic [1:0]  S_RUN   = RUN;
   localparam logic [1:0]  S_DRAIN = DRAIN;
   localparam logic [1:0]  S_HALT  = HALT;

   logic [1:0]    r_state;
   logic [1:0]    w_state_n;
   logic [31:0]   r_pc;
   logic [31:0]   w_target;
   logic [31:0]   w_tag_pc;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] w_drop_n;
   logic [CW-1:0] w_tag_cnt;
   logic [CW-1:0] w_buf_cnt;
   logic          r_flush;
   logic          w_misalign;
   logic          w_acc;
   logic          w_push;
   logic          w_pop;
   fetch_entry_t  w_entry;
   fetch_entry_t  w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_misalign = branch_target[1:0] != 2'b00;
   assign w_target   = branch_target;
`else
   assign w_misalign = 1'b0;
   assign w_target   = branch_target & 32'hFFFF_FFFC;
`endif

   // Credits cover both in-flight reads and buffered words, so the buffer never overflows.
   assign bus.imem_req_valid = (r_state == S_RUN) && !branched &&
                               (({1'b0, w_tag_cnt} + {1'b0, w_buf_cnt}) < DEPTH_C);
   assign bus.imem_req_addr  = r_pc;
   assign bus.if_valid       = w_buf_cnt != '0;
   assign bus.if_pc          = w_head.pc;
   assign bus.if_instr       = w_head.instr;
   assign bus.flush          = r_flush;

   assign w_acc   = bus.imem_req_valid && bus.imem_req_ready;
   assign w_push  = bus.imem_resp_valid && (r_drop == '0);
   assign w_pop   = bus.if_valid && bus.if_ready && !branched;
   assign w_entry = '{pc: w_tag_pc, instr: bus.imem_resp_data};
   // Every read still outstanding at a redirect is stale, except one retiring right now.
   assign w_drop_n  = branched ? w_tag_cnt - CW'(bus.imem_resp_valid)
                               : r_drop - CW'(bus.imem_resp_valid && r_drop != '0);
   assign w_state_n = branched ? (w_misalign ? S_HALT : (w_drop_n != '0 ? S_DRAIN : S_RUN))
                    : (r_state == S_BOOT || (r_state == S_DRAIN && w_drop_n == '0)) ? S_RUN
                    : r_state;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_BOOT;
         r_pc    <= RESET_PC;
         r_drop  <= '0;
         r_flush <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_drop  <= w_drop_n;
         r_flush <= branched;
         if (branched && !w_misalign)
            r_pc <= w_target;
         else if (w_acc)
            r_pc <= r_pc + 32'd4;
      end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         misalign_trap <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_trap <= branched && w_misalign;
         if (branched && w_misalign)
            misalign_addr <= branch_target;
      end
`endif

   fetch_fifo #(.T(logic [31:0]), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (1'b0),
      .i_push  (w_acc),
      .i_pop   (bus.imem_resp_valid),
      .i_data  (r_pc),
      .o_data  (w_tag_pc),
      .o_count (w_tag_cnt)
   );

   fetch_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_buf_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (branched),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_entry),
      .o_data  (w_head),
      .o_count (w_buf_cnt)
   );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed stimulus, expected {pc,instr} queued and checked by a monitor.
module tb_fetch_pc_unit;
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic        clk;
   logic        rst_n;
   logic        branched;
   logic [31:0] branch_target;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_trap;
   logic [31:0] misalign_addr;
`endif
   fetch_pc_unit_if bus ();

   logic [31:0] exp_q [$];
   mreq_t       mq [$];
   int tests, fails, budget, lat, acc_cnt, del_cnt, cyc, base, peak, acc0, k;
   bit track;

   fetch_pc_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .branched      (branched),
      .branch_target (branch_target),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misalign_trap (misalign_trap),
      .misalign_addr (misalign_addr),
`endif
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while ((exp_q.size() != 0 || mq.size() != 0 || budget != 0 || bus.if_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(n < 300), 64'd1);
   endtask

   task automatic expect_pcs(logic [31:0] first, int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(first + 32'(4 * i));
   endtask

   // Memory model: accepts while budget remains, answers in order after 'lat' cycles.
   initial begin
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = word_of(mq[0].addr);
            void'(mq.pop_front());
         end else
            bus.imem_resp_valid = 1'b0;
         bus.imem_req_ready = budget > 0;
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            budget--;
            acc_cnt++;
         end
      end
   end

   // Monitor: every word decode takes must match the head of the expected queue.
   initial forever begin
      logic [31:0] e;
      @(negedge clk);
      #2;
      if (track && (acc_cnt - del_cnt - base) > peak)
         peak = acc_cnt - del_cnt - base;
      if (rst_n && bus.if_valid && bus.if_ready && !branched) begin
         del_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_delivery: got pc %h expected none", bus.if_pc);
         end else begin
            e = exp_q.pop_front();
            chk("deliver", {bus.if_pc, bus.if_instr}, {e, word_of(e)});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; branched = 1'b0; branch_target = '0; bus.if_ready = 1'b1;
      budget = 0; lat = 1; tests = 0; fails = 0; track = 1'b0; peak = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("reset_if_valid", 64'(bus.if_valid), 64'd0);
      chk("reset_flush", 64'(bus.flush), 64'd0);
      chk("reset_req_addr", 64'(bus.imem_req_addr), 64'h0);
      rst_n = 1'b1;
      // 1: sequential fetch from reset PC
      expect_pcs(32'h0, 4);
      budget = 4;
      wait_idle("t1_idle");
      // 2: decode stalls; credits cap outstanding+buffered at FIFO_DEPTH
      bus.if_ready = 1'b0;
      base = acc_cnt - del_cnt;
      acc0 = acc_cnt;
      track = 1'b1;
      expect_pcs(32'h10, 3);
      budget = 3;
      repeat (5) @(negedge clk);
      chk("t2_accepts_stalled", 64'(acc_cnt - acc0), 64'd2);
      bus.if_ready = 1'b1;
      wait_idle("t2_idle");
      track = 1'b0;
      chk("t2_peak_occupancy", 64'(peak), 64'd2);
      // 3: redirect with two reads in flight
      lat = 3;
      budget = 2;
      k = 0;
      while (mq.size() < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t3_two_in_flight", 64'(mq.size()), 64'd2);
      branched = 1'b1;
      branch_target = 32'h100;
      @(negedge clk);
      chk("t3_flush_pulse", 64'(bus.flush), 64'd1);
      branched = 1'b0;
      lat = 1;
      expect_pcs(32'h100, 2);
      budget = 2;
      @(negedge clk);
      chk("t3_flush_single", 64'(bus.flush), 64'd0);
      wait_idle("t3_idle");
      // 4: redirect while memory ready and decode ready with a buffered word
      bus.if_ready = 1'b0;
      budget = 1;
      k = 0;
      while (!bus.if_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t4_buffered_pc", {31'd0, bus.if_valid, bus.if_pc}, {31'd0, 1'b1, 32'h108});
      branched = 1'b1;
      branch_target = 32'h200;
      bus.if_ready = 1'b1;
      budget = 3;
      acc0 = acc_cnt;
      #2;
      chk("t4_no_req_on_branch", 64'(bus.imem_req_valid), 64'd0);
      @(negedge clk);
      branched = 1'b0;
      chk("t4_no_accept", 64'(acc_cnt - acc0), 64'd0);
      chk("t4_fifo_cleared", 64'(bus.if_valid), 64'd0);
      expect_pcs(32'h200, 1);
      budget = 1;
      wait_idle("t4_idle");
      // 5: PC wraps past the top of the address space
      branched = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      @(negedge clk);
      branched = 1'b0;
      expect_pcs(32'hFFFF_FFFC, 2);
      budget = 2;
      wait_idle("t5_idle");
      // 6: misaligned branch target
      branched = 1'b1;
      branch_target = 32'h102;
      @(negedge clk);
      branched = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("t6_trap_pulse", 64'(misalign_trap), 64'd1);
      chk("t6_trap_addr", 64'(misalign_addr), 64'h102);
      budget = 2;
      acc0 = acc_cnt;
      repeat (6) @(negedge clk);
      chk("t6_halt_no_req", 64'(acc_cnt - acc0), 64'd0);
      chk("t6_trap_single", 64'(misalign_trap), 64'd0);
      branched = 1'b1;
      branch_target = 32'h200;
      @(negedge clk);
      branched = 1'b0;
      expect_pcs(32'h200, 2);
`else
      expect_pcs(32'h100, 1);
      budget = 1;
`endif
      wait_idle("t6_idle");
      chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
